matmul_engine: RTL and testbench

Sequential signed matrix-multiply engine that sits directly downstream of the two operand memories. It reads their flattened matrix outputs (A and B) and computes C = A × B one multiply-accumulate per cycle. Each finished C element goes out through a single write port to the result scratchpad. It is started by the control/register block, which holds the operand memories quiescent while `busy_o` is high.

---
 rtl/matmul_engine.sv | 230 +++++++++++++++++++++++
 tb/tb_matmul_engine.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_engine.sv
// ---------------------------------------------------------------------------
// matmul_engine
//
// Sequential signed matrix multiply, C = A x B, one multiply-accumulate per
// clock. Operands are read live from the flattened operand-memory outputs;
// each finished C element is emitted through a single registered write port.
//
// Optional feature macro: MATMUL_SAT_EN
//   defined   - results saturate to the signed RES_WIDTH range, ovf_o is a
//               sticky "some element saturated" flag cleared by the next start
//   undefined - results wrap (low RES_WIDTH bits), ovf_o tied to 0
//
// Ports
//   clk_i       clock, rising edge
//   rst_n_i     asynchronous active-low reset
//   start_i     one-cycle start request, honoured only in IDLE
//   n_dim_i     rows of A minus 1
//   k_dim_i     cols of A / rows of B minus 1
//   m_dim_i     cols of B minus 1
//   mat_a_i     flat A, element (r,c) at [(r*MAX_DIM+c)*DATA_WIDTH +: DATA_WIDTH]
//   mat_b_i     flat B, same packing
//   busy_o      high from the cycle after an accepted start until done_o
//   done_o      one-cycle completion pulse
//   res_we_o    result write strobe, one cycle per C element
//   res_addr_o  result address, i*MAX_DIM + j
//   res_data_o  signed result element
//   ovf_o       sticky overflow flag (saturation build only)
// ---------------------------------------------------------------------------
module matmul_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_DIM    = 4,
    parameter int RES_WIDTH  = 16
) (
    input  logic                                    clk_i,
    input  logic                                    rst_n_i,
    input  logic                                    start_i,
    input  logic [$clog2(MAX_DIM)-1:0]              n_dim_i,
    input  logic [$clog2(MAX_DIM)-1:0]              k_dim_i,
    input  logic [$clog2(MAX_DIM)-1:0]              m_dim_i,
    input  logic [DATA_WIDTH*MAX_DIM*MAX_DIM-1:0]   mat_a_i,
    input  logic [DATA_WIDTH*MAX_DIM*MAX_DIM-1:0]   mat_b_i,
    output logic                                    busy_o,
    output logic                                    done_o,
    output logic                                    res_we_o,
    output logic [2*$clog2(MAX_DIM)-1:0]            res_addr_o,
    output logic [RES_WIDTH-1:0]                    res_data_o,
    output logic                                    ovf_o
);
    localparam int DIM_W  = $clog2(MAX_DIM);
    localparam int PROD_W = 2 * DATA_WIDTH;
    // K+1 <= MAX_DIM products of PROD_W bits never exceed PROD_W + DIM_W bits
    localparam int ACC_W  = PROD_W + DIM_W;
    localparam int N_ELEM = MAX_DIM * MAX_DIM;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_WRITE, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [DIM_W-1:0]         n_q, n_d, kdim_q, kdim_d, m_q, m_d;
    logic [DIM_W-1:0]         i_q, i_d, j_q, j_d, k_q, k_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d, acc_sum;
    logic                     busy_q, busy_d, done_q, done_d, we_q, we_d;
    logic [2*DIM_W-1:0]       addr_q, addr_d;
    logic [RES_WIDTH-1:0]     data_q, data_d, res_val;

    // Unpack the flat operand buses so elements can be indexed by {row, col}
    logic signed [DATA_WIDTH-1:0] a_elem [N_ELEM];
    logic signed [DATA_WIDTH-1:0] b_elem [N_ELEM];

    genvar gi;
    generate
        for (gi = 0; gi < N_ELEM; gi++) begin : g_unpack
            assign a_elem[gi] = mat_a_i[gi*DATA_WIDTH +: DATA_WIDTH];
            assign b_elem[gi] = mat_b_i[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // MAX_DIM is a power of two, so {row, col} equals row*MAX_DIM + col
    logic signed [PROD_W-1:0] prod;
    assign prod    = a_elem[{i_q, k_q}] * b_elem[{k_q, j_q}];
    // The k=0 term loads instead of adding, so no separate clear cycle is needed
    assign acc_sum = (k_q == '0) ? ACC_W'(prod) : acc_q + ACC_W'(prod);

`ifdef MATMUL_SAT_EN
    localparam int EXT_W = (ACC_W > RES_WIDTH) ? ACC_W : RES_WIDTH;
    localparam logic signed [EXT_W-1:0] RES_MAX =
        {{(EXT_W-RES_WIDTH+1){1'b0}}, {(RES_WIDTH-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] RES_MIN =
        {{(EXT_W-RES_WIDTH+1){1'b1}}, {(RES_WIDTH-1){1'b0}}};

    logic signed [EXT_W-1:0] acc_ext;
    logic                    sat_hit;
    logic                    ovf_q, ovf_d;

    always_comb begin
        acc_ext = EXT_W'(acc_sum);
        sat_hit = 1'b0;
        res_val = acc_ext[RES_WIDTH-1:0];
        if (acc_ext > RES_MAX) begin
            res_val = RES_MAX[RES_WIDTH-1:0];
            sat_hit = 1'b1;
        end else if (acc_ext < RES_MIN) begin
            res_val = RES_MIN[RES_WIDTH-1:0];
            sat_hit = 1'b1;
        end
    end
    assign ovf_o = ovf_q;
`else
    assign res_val = RES_WIDTH'(acc_sum);
    assign ovf_o   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        kdim_d  = kdim_q;
        m_d     = m_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
`ifdef MATMUL_SAT_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    n_d     = n_dim_i;
                    kdim_d  = k_dim_i;
                    m_d     = m_dim_i;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    busy_d  = 1'b1;
`ifdef MATMUL_SAT_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = acc_sum;
                if (k_q == kdim_q) begin
                    // Register the finished element so it is presented
                    // together with the strobe during the WRITE cycle
                    we_d    = 1'b1;
                    addr_d  = {i_q, j_q};
                    data_d  = res_val;
`ifdef MATMUL_SAT_EN
                    ovf_d   = ovf_q | sat_hit;
`endif
                    state_d = S_WRITE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_WRITE: begin
                k_d = '0;
                if (i_q == n_q && j_q == m_q) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    if (j_q == m_q) begin
                        j_d = '0;
                        i_d = i_q + 1'b1;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                    state_d = S_MAC;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            kdim_q  <= '0;
            m_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
`ifdef MATMUL_SAT_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            kdim_q  <= kdim_d;
            m_q     <= m_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
`ifdef MATMUL_SAT_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign res_we_o   = we_q;
    assign res_addr_o = addr_q;
    assign res_data_o = data_q;

endmodule

// File: tb/tb_matmul_engine.sv
// ---------------------------------------------------------------------------
// tb_matmul_engine
//
// Self-checking bench for matmul_engine. Directed vectors come from a table
// of {dims, operands, expected constants}; random jobs are compared against
// a plain-arithmetic reference (sum of products, then wrap or clamp).
// Hand-written sequences cover start-while-busy and mid-run reset.
// Cycle bookkeeping: t0 is the posedge count right after the start edge,
// i.e. the first MAC cycle.
// ---------------------------------------------------------------------------
module tb_matmul_engine;
    localparam int DW = 8;
    localparam int MD = 4;
    localparam int RW = 16;
    localparam int LG = 2;
    localparam int FW = DW * MD * MD;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [LG-1:0] n_dim = '0, k_dim = '0, m_dim = '0;
    logic [FW-1:0] mat_a = '0, mat_b = '0;
    logic          busy, done, we, ovf;
    logic [2*LG-1:0] addr;
    logic [RW-1:0] data;

    matmul_engine #(.DATA_WIDTH(DW), .MAX_DIM(MD), .RES_WIDTH(RW)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
        .n_dim_i(n_dim), .k_dim_i(k_dim), .m_dim_i(m_dim),
        .mat_a_i(mat_a), .mat_b_i(mat_b),
        .busy_o(busy), .done_o(done), .res_we_o(we),
        .res_addr_o(addr), .res_data_o(data), .ovf_o(ovf)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- write / done monitor ----------------
    typedef struct packed {
        logic [2*LG-1:0] addr;
        logic [RW-1:0]   data;
        logic [31:0]     cyc_at;
    } wr_t;
    wr_t  wr_q[$];
    wr_t  mon_w;
    int   done_cnt = 0;
    int   done_at  = 0;
    int   busy_cnt = 0;
    logic ovf_at_done = 1'b0;

    always @(negedge clk) begin
        if (we) begin
            mon_w.addr   = addr;
            mon_w.data   = data;
            mon_w.cyc_at = cyc;
            wr_q.push_back(mon_w);
        end
        if (done) begin
            done_cnt++;
            done_at     = cyc;
            ovf_at_done = ovf;
        end
        if (busy) busy_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int a_m [MD][MD];
    int b_m [MD][MD];
    int cur_n, cur_k, cur_m, t0;

    function automatic longint elem_sum(input int i, input int j, input int kmax);
        longint s = 0;
        for (int kk = 0; kk <= kmax; kk++) s += longint'(a_m[i][kk]) * longint'(b_m[kk][j]);
        return s;
    endfunction

    function automatic bit elem_sat(input longint s);
`ifdef MATMUL_SAT_EN
        return (s > 32767) || (s < -32768);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [RW-1:0] elem_expect(input longint s);
`ifdef MATMUL_SAT_EN
        if (s > 32767)  return 16'h7FFF;
        if (s < -32768) return 16'h8000;
`endif
        return s[RW-1:0];
    endfunction

    function automatic logic [FW-1:0] put(input logic [FW-1:0] f, input int r, input int c, input int v);
        logic [FW-1:0] g = f;
        g[(r*MD+c)*DW +: DW] = v[DW-1:0];
        return g;
    endfunction

    function automatic logic [FW-1:0] fill(input int v);
        logic [FW-1:0] g = '0;
        for (int e = 0; e < MD*MD; e++) g = put(g, e / MD, e % MD, v);
        return g;
    endfunction

    task automatic load_from_flats(input logic [FW-1:0] af, input logic [FW-1:0] bf);
        for (int r = 0; r < MD; r++)
            for (int c = 0; c < MD; c++) begin
                a_m[r][c] = int'($signed(af[(r*MD+c)*DW +: DW]));
                b_m[r][c] = int'($signed(bf[(r*MD+c)*DW +: DW]));
            end
    endtask

    // Drive a start pulse; returns at the first MAC cycle (posedge count t0)
    task automatic launch(input int n, input int k, input int m);
        @(negedge clk);
        for (int r = 0; r < MD; r++)
            for (int c = 0; c < MD; c++) begin
                mat_a[(r*MD+c)*DW +: DW] = DW'(a_m[r][c]);
                mat_b[(r*MD+c)*DW +: DW] = DW'(b_m[r][c]);
            end
        n_dim = LG'(n); k_dim = LG'(k); m_dim = LG'(m);
        cur_n = n; cur_k = k; cur_m = m;
        wr_q.delete();
        done_cnt    = 0;
        busy_cnt    = 0;
        ovf_at_done = 1'b0;
        start       = 1'b1;
        t0          = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        // dims must be latched, so scramble the live inputs
        n_dim = LG'($urandom); k_dim = LG'($urandom); m_dim = LG'($urandom);
        check("ovf_clr_on_start", ovf, 1'b0);
        check("busy_first_mac", busy, 1'b1);
    endtask

    task automatic finish_and_check(input string tag);
        int total, nel;
        bit any_sat;
        total = (cur_n + 1) * (cur_m + 1) * (cur_k + 2);
        nel   = (cur_n + 1) * (cur_m + 1);
        repeat (total + 3) @(negedge clk);
        check($sformatf("%s.done_cnt", tag), done_cnt, 1);
        check($sformatf("%s.done_cyc", tag), done_at - t0, total);
        check($sformatf("%s.busy_len", tag), busy_cnt, total);
        check($sformatf("%s.busy_end", tag), busy, 1'b0);
        check($sformatf("%s.n_writes", tag), wr_q.size(), nel);
        any_sat = 1'b0;
        for (int idx = 0; idx < nel; idx++) begin
            int i, j;
            longint s;
            i = idx / (cur_m + 1);
            j = idx % (cur_m + 1);
            s = elem_sum(i, j, cur_k);
            if (elem_sat(s)) any_sat = 1'b1;
            if (idx < wr_q.size()) begin
                check($sformatf("%s.addr[%0d]", tag, idx), wr_q[idx].addr, i*MD + j);
                check($sformatf("%s.data[%0d]", tag, idx), wr_q[idx].data, elem_expect(s));
                check($sformatf("%s.wcyc[%0d]", tag, idx), wr_q[idx].cyc_at - t0,
                      (idx + 1) * (cur_k + 2) - 1);
            end
        end
        check($sformatf("%s.ovf", tag), ovf_at_done, any_sat);
    endtask

    task automatic check_outputs_zero(input string tag);
        check($sformatf("%s.busy", tag), busy, 1'b0);
        check($sformatf("%s.done", tag), done, 1'b0);
        check($sformatf("%s.we",   tag), we,   1'b0);
        check($sformatf("%s.addr", tag), addr, '0);
        check($sformatf("%s.data", tag), data, '0);
        check($sformatf("%s.ovf",  tag), ovf,  1'b0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic [LG-1:0]   n, k, m;
        logic [FW-1:0]   a_flat, b_flat;
        logic [7:0]      exp_done;       // done cycle offset from start edge t
        logic [RW-1:0]   exp_first, exp_last;
        logic [2*LG-1:0] exp_last_addr;
        logic            exp_ovf;
    } vec_t;
    vec_t vecs [4];

    initial begin
        int nw;
        vecs[0].n = 1; vecs[0].k = 1; vecs[0].m = 1;
        vecs[0].a_flat = put(put(put(put('0, 0, 0, 1), 0, 1, 2), 1, 0, 3), 1, 1, 4);
        vecs[0].b_flat = put(put('0, 0, 0, 1), 1, 1, 1);
        vecs[0].exp_done = 13; vecs[0].exp_first = 16'd1; vecs[0].exp_last = 16'd4;
        vecs[0].exp_last_addr = 5; vecs[0].exp_ovf = 1'b0;

        vecs[1].n = 0; vecs[1].k = 2; vecs[1].m = 1;
        vecs[1].a_flat = put(put(put('0, 0, 0, 1), 0, 1, 2), 0, 2, 3);
        vecs[1].b_flat = put(put(put(put('0, 0, 0, 1), 1, 1, 1), 2, 0, 1), 2, 1, 1);
        vecs[1].exp_done = 9; vecs[1].exp_first = 16'd4; vecs[1].exp_last = 16'd5;
        vecs[1].exp_last_addr = 1; vecs[1].exp_ovf = 1'b0;

        vecs[2].n = 3; vecs[2].k = 3; vecs[2].m = 3;
        vecs[2].a_flat = fill(-1);
        vecs[2].b_flat = fill(2);
        vecs[2].exp_done = 81; vecs[2].exp_first = 16'hFFF8; vecs[2].exp_last = 16'hFFF8;
        vecs[2].exp_last_addr = 15; vecs[2].exp_ovf = 1'b0;

        vecs[3].n = 3; vecs[3].k = 3; vecs[3].m = 3;
        vecs[3].a_flat = fill(-128);
        vecs[3].b_flat = fill(-128);
        vecs[3].exp_done = 81; vecs[3].exp_last_addr = 15;
`ifdef MATMUL_SAT_EN
        vecs[3].exp_first = 16'h7FFF; vecs[3].exp_last = 16'h7FFF; vecs[3].exp_ovf = 1'b1;
`else
        vecs[3].exp_first = 16'h0000; vecs[3].exp_last = 16'h0000; vecs[3].exp_ovf = 1'b0;
`endif

        // power-on reset, applied asynchronously between clock edges
        #1 rst_n = 1'b0;
        #1 check_outputs_zero("por");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_no_busy", busy, 1'b0);
        check("idle_no_write", wr_q.size(), 0);

        for (int v = 0; v < 4; v++) begin
            load_from_flats(vecs[v].a_flat, vecs[v].b_flat);
            launch(vecs[v].n, vecs[v].k, vecs[v].m);
            finish_and_check($sformatf("vec%0d", v));
            check($sformatf("vec%0d.tbl_done", v), done_at - t0 + 1, vecs[v].exp_done);
            check($sformatf("vec%0d.tbl_ovf", v), ovf_at_done, vecs[v].exp_ovf);
            if (wr_q.size() > 0) begin
                check($sformatf("vec%0d.tbl_first", v), wr_q[0].data, vecs[v].exp_first);
                check($sformatf("vec%0d.tbl_last", v), wr_q[wr_q.size()-1].data, vecs[v].exp_last);
                check($sformatf("vec%0d.tbl_last_addr", v), wr_q[wr_q.size()-1].addr,
                      vecs[v].exp_last_addr);
            end
            $display("vec%0d dims=%0d/%0d/%0d writes=%0d done_at=t+%0d ovf=%0b",
                     v, vecs[v].n, vecs[v].k, vecs[v].m, wr_q.size(), done_at - t0 + 1, ovf_at_done);
        end

        // start pulse mid-run must be ignored
        load_from_flats(vecs[0].a_flat, vecs[0].b_flat);
        launch(1, 1, 1);
        repeat (4) @(negedge clk);
        start = 1'b1; n_dim = 2'd0; k_dim = 2'd0; m_dim = 2'd0;
        @(negedge clk);
        start = 1'b0;
        finish_and_check("busy_start");
        repeat (10) @(negedge clk);
        check("busy_start.no_rerun_done", done_cnt, 1);
        check("busy_start.no_rerun_wr", wr_q.size(), 4);
        $display("busy_start writes=%0d done_cnt=%0d", wr_q.size(), done_cnt);

        // reset mid-run
        launch(1, 1, 1);
        repeat (6) @(negedge clk);
        check("rst.busy_pre", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("rst_async");
        nw = wr_q.size();
        check("rst.writes_before", nw, 2);
        repeat (3) @(negedge clk);
        check_outputs_zero("rst_hold");
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("rst.no_more_writes", wr_q.size(), 2);
        check("rst.no_done", done_cnt, 0);
        check("rst.idle_busy", busy, 1'b0);
        $display("mid_run_reset writes_before=%0d writes_after=%0d", nw, wr_q.size());
        launch(1, 1, 1);
        finish_and_check("after_rst");

        // random jobs against the reference model
        for (int r = 0; r < 25; r++) begin
            int n, k, m;
            n = $urandom_range(0, 3);
            k = $urandom_range(0, 3);
            m = $urandom_range(0, 3);
            for (int x = 0; x < MD; x++)
                for (int y = 0; y < MD; y++) begin
                    a_m[x][y] = int'($urandom_range(0, 255)) - 128;
                    b_m[x][y] = int'($urandom_range(0, 255)) - 128;
                end
            launch(n, k, m);
            finish_and_check($sformatf("rnd%0d", r));
            $display("rnd%0d dims=%0d/%0d/%0d writes=%0d done_at=t+%0d",
                     r, n, k, m, wr_q.size(), done_at - t0 + 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
